// File: rtl/clk_div_sequencer.sv
// ---------------------------------------------------------------------------
// clk_div_sequencer
//   Power-of-two clock divider whose ratio can be reprogrammed at runtime.
//   The divided output has a 50% duty cycle. A new ratio arrives over a
//   valid/ready handshake. It is applied only at a period boundary, where
//   div_out falls. A settle gap with div_out held low follows, so the output
//   never produces a runt pulse.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_en         run request, sampled at period ends
//   i_cfg_valid  new ratio code offered
//   i_cfg_n      requested ratio code (clamped to N_MAX)
//   o_cfg_ready  ratio can be accepted this cycle (IDLE or RUN)
//   o_div_out    divided clock, registered
//   o_div_tick   one-cycle pulse in the cycle o_div_out has just toggled
//   o_active_n   ratio code currently driving o_div_out
//   o_locked     running at o_active_n with nothing pending
//   o_busy       accepted change still in progress (PEND or SETTLE)
// ---------------------------------------------------------------------------
module clk_div_sequencer #(
  parameter int CNT_W      = 8,
  parameter int N_MAX      = 7,
  parameter int N_RST      = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_cfg_valid,
  input  logic [2:0] i_cfg_n,
  output logic       o_cfg_ready,
  output logic       o_div_out,
  output logic       o_div_tick,
  output logic [2:0] o_active_n,
  output logic       o_locked,
  output logic       o_busy
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_SETTLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_divOut;
  logic             r_divTick;
  logic [2:0]       r_activeN;
  logic [2:0]       r_pendN;
  logic [SW-1:0]    r_settleCnt;

  logic [CNT_W-1:0] w_halfLast;
  logic             w_halfDone;
  logic             w_periodEnd;
  logic             w_ready;
  logic             w_xfer;
  logic [2:0]       w_clampN;

  // The last count of a half period is 2**active_n - 1.
  assign w_halfLast  = (CNT_W'(1) << r_activeN) - CNT_W'(1);
  assign w_halfDone  = (r_cnt == w_halfLast);
  // A period ends on the toggle that takes div_out from 1 to 0.
  assign w_periodEnd = w_halfDone && r_divOut;

  // Ready depends only on the state register, so there is no path from
  // cfg_valid back to cfg_ready.
  assign w_ready  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_xfer   = i_cfg_valid && w_ready;
  assign w_clampN = (int'(i_cfg_n) > N_MAX) ? 3'(N_MAX) : i_cfg_n;

  // The FSM and the divide datapath share one register process. The tick
  // pulse defaults low and is raised on any edge that toggles div_out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_divOut    <= 1'b0;
      r_divTick   <= 1'b0;
      r_activeN   <= 3'(N_RST);
      r_pendN     <= '0;
      r_settleCnt <= '0;
    end else begin
      r_divTick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_divOut <= 1'b0;
          if (w_xfer) r_activeN <= w_clampN;
          if (i_en) r_state <= S_RUN;
        end
        S_RUN, S_PEND: begin
          if (w_halfDone) begin
            r_cnt     <= '0;
            r_divOut  <= ~r_divOut;
            r_divTick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (r_state == S_RUN) begin
            // An accepted change waits for the next period end, even when
            // it arrives on a period end itself.
            if (w_xfer) begin
              r_pendN <= w_clampN;
              r_state <= S_PEND;
            end else if (w_periodEnd && !i_en) begin
              r_state <= S_IDLE;
            end
          end else if (w_periodEnd) begin
            r_activeN   <= r_pendN;
            r_settleCnt <= '0;
            r_state     <= i_en ? S_SETTLE : S_IDLE;
          end
        end
        S_SETTLE: begin
          r_cnt    <= '0;
          r_divOut <= 1'b0;
          if (r_settleCnt == SW'(SETTLE_CYC - 1)) begin
            r_settleCnt <= '0;
            r_state     <= i_en ? S_RUN : S_IDLE;
          end else begin
            r_settleCnt <= r_settleCnt + SW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cfg_ready = w_ready;
  assign o_div_out   = r_divOut;
  assign o_div_tick  = r_divTick;
  assign o_active_n  = r_activeN;
  assign o_locked    = (r_state == S_RUN);
  assign o_busy      = (r_state == S_PEND) || (r_state == S_SETTLE);

endmodule

// File: tb/tb_clk_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clk_div_sequencer
//   Self-checking bench for clk_div_sequencer, built with N_MAX=5 so that
//   clamping is visible. A behavioural model tracks the cycles elapsed since
//   the divider started. It derives div_out from that age by arithmetic and
//   is compared with the DUT on every falling clock edge. Directed sequences
//   pin key values with literals. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_clk_div_sequencer;

  localparam int NMAX   = 5;
  localparam int NRST   = 1;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfgValid = 1'b0;
  logic [2:0] cfgN = '0;
  logic       cfgReady, divOut, divTick, locked, busy;
  logic [2:0] activeN;

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  always #5 clk = ~clk;

  clk_div_sequencer #(
    .CNT_W(8), .N_MAX(NMAX), .N_RST(NRST), .SETTLE_CYC(SETTLE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_valid(cfgValid),
    .i_cfg_n(cfgN), .o_cfg_ready(cfgReady), .o_div_out(divOut),
    .o_div_tick(divTick), .o_active_n(activeN), .o_locked(locked),
    .o_busy(busy)
  );

  // Model state: mRun = divider running (steady or with a change pending),
  // mAge = cycles since the run started, mSettle = settle cycles remaining.
  bit mRun = 0, mPend = 0, mTick = 0;
  int mPendN = 0, mSettle = 0, mActive = NRST, mAge = 0;
  int mH, mNext, mClamp;
  bit mXfer;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit v, input logic [2:0] n);
    en       = e;
    cfgValid = v;
    cfgN     = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: advance one clock from the rules of the divider.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mRun = 0; mPend = 0; mTick = 0; mPendN = 0;
      mSettle = 0; mActive = NRST; mAge = 0;
    end else begin
      mXfer  = cfgValid && !(mPend || mSettle > 0);
      mClamp = (int'(cfgN) > NMAX) ? NMAX : int'(cfgN);
      mH     = 1 << mActive;
      mTick  = 0;
      if (!mRun && mSettle == 0) begin
        if (mXfer) mActive = mClamp;
        if (en) begin mRun = 1; mAge = 0; end
      end else if (mSettle > 0) begin
        mSettle--;
        if (mSettle == 0 && en) begin mRun = 1; mAge = 0; end
      end else begin
        mNext = mAge + 1;
        mTick = (mNext % mH) == 0;
        if ((mNext % (2 * mH)) == 0 && mPend) begin
          mActive = mPendN;
          mPend   = 0;
          mRun    = 0;
          mSettle = en ? SETTLE : 0;
        end else if ((mNext % (2 * mH)) == 0 && !mXfer && !en) begin
          mRun = 0;
        end else begin
          mAge = mNext;
          if (mXfer && !mPend) begin mPend = 1; mPendN = mClamp; end
        end
      end
    end
  end

  // Compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (!rst && checkEn) begin
      checkOutput("div_out", int'(divOut), mRun ? ((mAge >> mActive) & 1) : 0);
      checkOutput("div_tick", int'(divTick), int'(mTick));
      checkOutput("active_n", int'(activeN), mActive);
      checkOutput("locked", int'(locked), int'(mRun && !mPend));
      checkOutput("busy", int'(busy), int'(mPend || mSettle > 0));
      checkOutput("cfg_ready", int'(cfgReady), int'(!(mPend || mSettle > 0)));
    end
  end

  initial begin
    int cnt;
    bit hit;
    applyStimulus(0, 0, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkEn = 1;
    #1;
    checkOutput("rst_div_out", int'(divOut), 0);
    checkOutput("rst_active_n", int'(activeN), NRST);
    checkOutput("rst_cfg_ready", int'(cfgReady), 1);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Divide by 4: first rise two cycles after the run starts, 2 high, 2 low.
    applyStimulus(1, 0, 3'd0);
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt++; if (divOut) break; end
    checkOutput("first_rise_cycles", cnt, 2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt++; if (!divOut) break; end
    checkOutput("high_cycles", cnt, 2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt++; if (divOut) break; end
    checkOutput("low_cycles", cnt, 2);
    checkOutput("run_locked", int'(locked), 1);

    // Stop, then load ratio 3 while idle: applied on the next cycle.
    applyStimulus(0, 0, 3'd0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin step(); if (!locked && !busy) begin hit = 1; break; end end
    checkOutput("reach_idle", int'(hit), 1);
    applyStimulus(0, 1, 3'd3);
    step();
    applyStimulus(0, 0, 3'd0);
    checkOutput("idle_load_active_n", int'(activeN), 3);
    applyStimulus(1, 0, 3'd0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin step(); if (divTick) begin hit = 1; break; end end
    checkOutput("tick_seen_n3", int'(hit), 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(); cnt++; if (divTick) break; end
    checkOutput("tick_spacing_n3", cnt, 8);

    // Request 7 with N_MAX=5: the ratio is clamped to 5.
    applyStimulus(1, 1, 3'd7);
    step();
    applyStimulus(1, 0, 3'd0);
    checkOutput("change_busy", int'(busy), 1);
    hit = 0;
    for (int i = 0; i < 100; i++) begin step(); if (!busy) begin hit = 1; break; end end
    checkOutput("change_done", int'(hit), 1);
    checkOutput("clamped_active_n", int'(activeN), 5);
    checkOutput("relocked", int'(locked), 1);
    hit = 0;
    for (int i = 0; i < 80; i++) begin step(); if (divTick) begin hit = 1; break; end end
    cnt = 0;
    for (int i = 0; i < 80; i++) begin step(); cnt++; if (divTick) break; end
    checkOutput("tick_spacing_n5", cnt, 32);

    // Drop en in the high phase: the high phase completes, then the divider stops.
    hit = 0;
    for (int i = 0; i < 80; i++) begin step(); if (divOut) begin hit = 1; break; end end
    checkOutput("high_phase_seen", int'(hit), 1);
    applyStimulus(0, 0, 3'd0);
    hit = 0;
    for (int i = 0; i < 80; i++) begin step(); if (!locked) begin hit = 1; break; end end
    checkOutput("stopped", int'(hit), 1);
    checkOutput("stopped_div_out", int'(divOut), 0);

    // Assert reset asynchronously during SETTLE.
    applyStimulus(1, 1, 3'd1);
    step();
    applyStimulus(1, 0, 3'd0);
    repeat (3) step();
    applyStimulus(1, 1, 3'd2);
    step();
    applyStimulus(1, 0, 3'd0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy && divTick && !divOut) begin hit = 1; break; end
    end
    checkOutput("settle_reached", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_active_n", int'(activeN), NRST);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_tick", int'(divTick), 0);
    checkOutput("arst_ready", int'(cfgReady), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized phase checked by the model on every cycle.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
                    3'($urandom_range(0, 7)));
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
      step();
    end

    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
